// File: rtl/motor_run_timer_if.sv
// Control/status bundle between the switch/FSM front end and the motor run timer.
// The front end drives mode/pause/restart and reads back elapsed time and expiry.
`default_nettype none

interface motor_run_timer_if #(
    parameter int MODE_W = 2,
    parameter int SEC_W  = 6
);
    logic [MODE_W-1:0] i_mode;
    logic              i_pause;
    logic              i_restart;
    logic [SEC_W-1:0]  o_sec;
    logic [6:0]        o_msec;
    logic [SEC_W-1:0]  o_remain_sec;
    logic              o_expired;
    logic              o_done;
    logic [1:0]        o_state;

    modport master (
        output i_mode, i_pause, i_restart,
        input  o_sec, o_msec, o_remain_sec, o_expired, o_done, o_state
    );

    modport slave (
        input  i_mode, i_pause, i_restart,
        output o_sec, o_msec, o_remain_sec, o_expired, o_done, o_state
    );
endinterface

`default_nettype wire

// File: rtl/motor_run_timer.sv
// Millisecond/second run timer: free-running seconds in mode 0, otherwise a timed
// run of mode*DUR_STEP_SEC seconds ending in a latched expiry and a one-cycle done pulse.
`default_nettype none

module motor_run_timer #(
    parameter int TICK_CYCLES  = 1,
    parameter int MODE_W       = 2,
    parameter int DUR_STEP_SEC = 10,
    parameter int SEC_W        = 6
) (
    input  logic              i_clk,
    input  logic              i_reset,
    motor_run_timer_if.slave  bus
);
    localparam int DIV_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(TICK_CYCLES - 1);
    localparam logic [9:0]       MSEC_LAST = 10'd999;
    localparam logic [SEC_W-1:0] FREE_LAST = SEC_W'(59);
    localparam logic [SEC_W-1:0] DUR_STEP  = SEC_W'(DUR_STEP_SEC);

    typedef enum logic [1:0] {
        ST_FREE    = 2'b00,
        ST_RUN     = 2'b01,
        ST_EXPIRED = 2'b10
    } state_t;

    logic [DIV_W-1:0]  r_div;
    logic [9:0]        r_msec;
    logic [SEC_W-1:0]  r_sec;
    logic [MODE_W-1:0] r_mode;
    state_t            r_state;
    logic              r_done;

    logic [SEC_W-1:0]  target;
    logic [SEC_W-1:0]  sec_next;
    logic              mode_change;
    logic              tick;
    logic              sec_event;

    // NOTE: every signal gets a value on every path through always_comb, so no latch is inferred.
    always_comb begin
        target      = SEC_W'(r_mode) * DUR_STEP;
        sec_next    = r_sec + SEC_W'(1);
        mode_change = (bus.i_mode != r_mode);
        tick        = (r_div == DIV_LAST) && (r_state != ST_EXPIRED) && !bus.i_pause;
        sec_event   = tick && (r_msec == MSEC_LAST);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_div   <= '0;
            r_msec  <= '0;
            r_sec   <= '0;
            r_mode  <= '0;
            r_state <= ST_FREE;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (mode_change || bus.i_restart) begin
                // On a plain restart i_mode equals r_mode, so one test covers both cases.
                r_div   <= '0;
                r_msec  <= '0;
                r_sec   <= '0;
                r_state <= (bus.i_mode == '0) ? ST_FREE : ST_RUN;
                if (mode_change) begin
                    r_mode <= bus.i_mode;
                end
            end else if (!bus.i_pause && (r_state != ST_EXPIRED)) begin
                r_div <= (r_div == DIV_LAST) ? '0 : r_div + DIV_W'(1);
                if (tick) begin
                    r_msec <= (r_msec == MSEC_LAST) ? '0 : r_msec + 10'd1;
                    if (sec_event) begin
                        if ((r_state == ST_RUN) && (sec_next == target)) begin
                            r_sec   <= target;
                            r_state <= ST_EXPIRED;
                            r_done  <= 1'b1;
                        end else if ((r_state == ST_FREE) && (r_sec == FREE_LAST)) begin
                            r_sec <= '0;
                        end else begin
                            r_sec <= sec_next;
                        end
                    end
                end
            end
        end
    end

    assign bus.o_sec        = r_sec;
    assign bus.o_msec       = 7'(r_msec / 10'd10);
    assign bus.o_remain_sec = (r_state == ST_FREE) ? '0 : target - r_sec;
    assign bus.o_expired    = (r_state == ST_EXPIRED);
    assign bus.o_done       = r_done;
    assign bus.o_state      = r_state;
endmodule

`default_nettype wire

// File: tb/tb_motor_run_timer.sv
// Self-checking bench for motor_run_timer: three instances run concurrently
// (free-run, prescaled timed run, and a vector-driven corner-case instance).
`timescale 1ns/1ps

module tb_motor_run_timer;
    localparam int MODE_W = 2;
    localparam int SEC_W  = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b, rst_c;

    motor_run_timer_if #(.MODE_W(MODE_W), .SEC_W(SEC_W)) a_if ();
    motor_run_timer_if #(.MODE_W(MODE_W), .SEC_W(SEC_W)) b_if ();
    motor_run_timer_if #(.MODE_W(MODE_W), .SEC_W(SEC_W)) c_if ();

    motor_run_timer #(.TICK_CYCLES(1)) dut_a (.i_clk(clk), .i_reset(rst_a), .bus(a_if.slave));
    motor_run_timer #(.TICK_CYCLES(2)) dut_b (.i_clk(clk), .i_reset(rst_b), .bus(b_if.slave));
    motor_run_timer #(.TICK_CYCLES(1)) dut_c (.i_clk(clk), .i_reset(rst_c), .bus(c_if.slave));

    typedef struct {
        int sec;
        int msec;
        int remain;
        int state;
        int expired;
        int done;
    } exp_t;

    typedef struct {
        string             name;
        logic [MODE_W-1:0] mode;
        bit                pause;
        bit                restart;
        int                cycles;
        exp_t              exp;
    } vec_t;

    int   n_tests = 0;
    int   n_fail  = 0;
    vec_t vecs[$];
    exp_t sb[$];
    int   part2_at;

    task automatic check(input string name, input int actual, input int expected);
        n_tests++;
        if (actual != expected) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    function automatic exp_t pack(input int sec, input int msec, input int remain,
                                  input int state, input int expired, input int done);
        exp_t e;
        e.sec = sec; e.msec = msec; e.remain = remain;
        e.state = state; e.expired = expired; e.done = done;
        return e;
    endfunction

    function automatic vec_t mk(input string name, input int mode, input bit pause,
                                input bit restart, input int cycles, input int sec,
                                input int msec, input int remain, input int state,
                                input int expired, input int done);
        vec_t v;
        v.name = name; v.mode = MODE_W'(mode); v.pause = pause; v.restart = restart;
        v.cycles = cycles;
        v.exp = pack(sec, msec, remain, state, expired, done);
        return v;
    endfunction

    task automatic check_outs(input string name, input exp_t act, input exp_t e);
        check({name, "_sec"},     act.sec,     e.sec);
        check({name, "_msec"},    act.msec,    e.msec);
        check({name, "_remain"},  act.remain,  e.remain);
        check({name, "_state"},   act.state,   e.state);
        check({name, "_expired"}, act.expired, e.expired);
        check({name, "_done"},    act.done,    e.done);
    endtask

    function automatic exp_t snap_c();
        return pack(int'(c_if.o_sec), int'(c_if.o_msec), int'(c_if.o_remain_sec),
                    int'(c_if.o_state), int'(c_if.o_expired), int'(c_if.o_done));
    endfunction

    task automatic wait_c(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic compare_c(input string name);
        exp_t e;
        if (sb.size() == 0) begin
            check({name, "_scoreboard_empty"}, 1, 0);
        end else begin
            e = sb.pop_front();
            check_outs(name, snap_c(), e);
        end
    endtask

    task automatic apply_vecs(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            c_if.i_mode    = vecs[i].mode;
            c_if.i_pause   = vecs[i].pause;
            c_if.i_restart = vecs[i].restart;
            sb.push_back(vecs[i].exp);
            wait_c(1);
            c_if.i_restart = 1'b0;
            if (vecs[i].cycles > 1) wait_c(vecs[i].cycles - 1);
            compare_c(vecs[i].name);
        end
    endtask

    // Free-run instance: 60 000 ms ticks walk o_sec through 0..59 and back to 0.
    task automatic thread_a();
        int bad = 0;
        int exp_seen = 0;
        int max_sec = 0;
        for (int n = 1; n <= 60500; n++) begin
            @(posedge clk); #1;
            if (int'(a_if.o_sec) != (n / 1000) % 60 || int'(a_if.o_msec) != (n % 1000) / 10
                || a_if.o_remain_sec != '0 || a_if.o_state != 2'b00)
                bad++;
            if (a_if.o_expired || a_if.o_done) exp_seen++;
            if (int'(a_if.o_sec) > max_sec) max_sec = int'(a_if.o_sec);
            if (n == 59999) begin
                check("t1_sec_59",  int'(a_if.o_sec),  59);
                check("t1_msec_99", int'(a_if.o_msec), 99);
            end
            if (n == 60000) begin
                check("t1_wrap_sec",  int'(a_if.o_sec),  0);
                check("t1_wrap_msec", int'(a_if.o_msec), 0);
            end
        end
        check("t1_model_mismatches", bad, 0);
        check("t1_expired_or_done_seen", exp_seen, 0);
        check("t1_max_sec", max_sec, 59);
    endtask

    // Timed run with a 2-cycle prescaler: expiry after 20 000 edges, then hold.
    task automatic thread_b();
        int bad = 0;
        int done_cnt = 0;
        int done_at = -1;
        int exp_at = -1;
        int es, em;
        @(posedge clk); #1;
        check("t2_release_state",  int'(b_if.o_state),        1);
        check("t2_release_remain", int'(b_if.o_remain_sec),  10);
        for (int n = 1; n <= 25000; n++) begin
            @(posedge clk); #1;
            if (b_if.o_done) begin
                done_cnt++;
                done_at = n;
            end
            if (b_if.o_expired && exp_at < 0) exp_at = n;
            if (n < 20000) begin
                es = (n / 2) / 1000;
                em = ((n / 2) % 1000) / 10;
                if (int'(b_if.o_sec) != es || int'(b_if.o_msec) != em
                    || int'(b_if.o_remain_sec) != 10 - es || b_if.o_state != 2'b01 || b_if.o_expired)
                    bad++;
            end else begin
                if (int'(b_if.o_sec) != 10 || b_if.o_msec != 7'd0 || b_if.o_remain_sec != '0
                    || b_if.o_state != 2'b10 || !b_if.o_expired)
                    bad++;
            end
            if (n == 19999) begin
                check("t2_pre_sec",    int'(b_if.o_sec),          9);
                check("t2_pre_msec",   int'(b_if.o_msec),        99);
                check("t2_pre_remain", int'(b_if.o_remain_sec),   1);
            end
            if (n == 20000) begin
                check("t2_exp_sec",    int'(b_if.o_sec),         10);
                check("t2_exp_remain", int'(b_if.o_remain_sec),   0);
                check("t2_exp_state",  int'(b_if.o_state),        2);
            end
        end
        check("t2_model_mismatches", bad, 0);
        check("t2_done_pulses", done_cnt, 1);
        check("t2_done_edge", done_at, 20000);
        check("t2_expired_edge", exp_at, 20000);
        check("t2_hold_sec", int'(b_if.o_sec), 10);
    endtask

    // Vector-driven instance: pause, async reset, mode changes and edge collisions.
    task automatic thread_c();
        sb.push_back(pack(0, 0, 20, 1, 0, 0));
        wait_c(1);
        compare_c("c_release_mode2");
        apply_vecs(0, part2_at);

        #2;
        rst_c = 1'b0;
        c_if.i_mode = 2'd3;
        #1;
        check_outs("t6_async_clear", snap_c(), pack(0, 0, 0, 0, 0, 0));
        #3;
        rst_c = 1'b1;
        sb.push_back(pack(0, 0, 30, 1, 0, 0));
        wait_c(1);
        compare_c("t6_release_mode3");

        apply_vecs(part2_at, vecs.size());
    endtask

    initial begin
        #(2_000_000);
        $display("FAIL watchdog: time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //                 name                mode p  r  cycles sec ms rem st ex dn
        vecs.push_back(mk("t3_run_1234ms",      2, 0, 0, 1234,   1, 23, 19, 1, 0, 0));
        vecs.push_back(mk("t3_run_5s",          2, 0, 0, 3766,   5,  0, 15, 1, 0, 0));
        vecs.push_back(mk("t3_pause_a",         2, 1, 0, 1500,   5,  0, 15, 1, 0, 0));
        vecs.push_back(mk("t3_pause_b",         2, 1, 0, 1500,   5,  0, 15, 1, 0, 0));
        vecs.push_back(mk("t3_resume",          2, 0, 0, 14999, 19, 99,  1, 1, 0, 0));
        vecs.push_back(mk("t3_expire",          2, 0, 0, 1,     20,  0,  0, 2, 1, 1));
        vecs.push_back(mk("t3_done_low",        2, 0, 0, 1,     20,  0,  0, 2, 1, 0));
        vecs.push_back(mk("t3_pause_expired",   2, 1, 0, 10,    20,  0,  0, 2, 1, 0));
        vecs.push_back(mk("t3_hold",            2, 0, 0, 500,   20,  0,  0, 2, 1, 0));
        part2_at = vecs.size();
        vecs.push_back(mk("t4_run_7s",          3, 0, 0, 7000,   7,  0, 23, 1, 0, 0));
        vecs.push_back(mk("t4_mode_3_to_1",     1, 0, 0, 1,      0,  0, 10, 1, 0, 0));
        vecs.push_back(mk("t5_near_expiry",     1, 0, 0, 9999,   9, 99,  1, 1, 0, 0));
        vecs.push_back(mk("t5_restart_on_exp",  1, 0, 1, 1,      0,  0, 10, 1, 0, 0));
        vecs.push_back(mk("t5_no_late_done",    1, 0, 0, 1,      0,  0, 10, 1, 0, 0));
        vecs.push_back(mk("t5_pre_sec_event",   1, 0, 0, 998,    0, 99, 10, 1, 0, 0));
        vecs.push_back(mk("t5_mode_on_sec",     2, 0, 0, 1,      0,  0, 20, 1, 0, 0));
        vecs.push_back(mk("t5_sec_after",       2, 0, 0, 1000,   1,  0, 19, 1, 0, 0));
        vecs.push_back(mk("free_mode0",         0, 0, 0, 1,      0,  0,  0, 0, 0, 0));
        vecs.push_back(mk("free_run",           0, 0, 0, 2500,   2, 50,  0, 0, 0, 0));
        vecs.push_back(mk("free_restart",       0, 0, 1, 1,      0,  0,  0, 0, 0, 0));
        vecs.push_back(mk("free_run_b",         0, 0, 0, 300,    0, 30,  0, 0, 0, 0));
        vecs.push_back(mk("restart_over_pause", 0, 1, 1, 1,      0,  0,  0, 0, 0, 0));
        vecs.push_back(mk("pause_free",         0, 1, 0, 50,     0,  0,  0, 0, 0, 0));
        vecs.push_back(mk("resume_free",        0, 0, 0, 100,    0, 10,  0, 0, 0, 0));

        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        a_if.i_mode = 2'd0; a_if.i_pause = 1'b0; a_if.i_restart = 1'b0;
        b_if.i_mode = 2'd1; b_if.i_pause = 1'b0; b_if.i_restart = 1'b0;
        c_if.i_mode = 2'd2; c_if.i_pause = 1'b0; c_if.i_restart = 1'b0;
        #1;
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        #2;
        check_outs("reset_a", pack(int'(a_if.o_sec), int'(a_if.o_msec), int'(a_if.o_remain_sec),
                   int'(a_if.o_state), int'(a_if.o_expired), int'(a_if.o_done)), pack(0, 0, 0, 0, 0, 0));
        check_outs("reset_b", pack(int'(b_if.o_sec), int'(b_if.o_msec), int'(b_if.o_remain_sec),
                   int'(b_if.o_state), int'(b_if.o_expired), int'(b_if.o_done)), pack(0, 0, 0, 0, 0, 0));
        check_outs("reset_c", snap_c(), pack(0, 0, 0, 0, 0, 0));
        #9;
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;

        fork
            thread_a();
            thread_b();
            thread_c();
        join

        check("scoreboard_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/motor_run_timer.md
# motor_run_timer

Parametrised successor to the motor-run timer: counts milliseconds and seconds from a clock-derived millisecond tick. A mode input selects between free-running seconds (wrap at 59) and a timed run of `mode × DUR_STEP_SEC` seconds that ends in a latched expiry plus a one-cycle done pulse. Beyond the earlier block, it adds:
- a configurable prescaler, pause, restart and remaining-time output;
- deterministic mode-change handling.

It sits between the switch/FSM front end and the PWM motor driver, which uses `o_expired` to stop the motor.

## Interface
- `TICK_CYCLES`, default 1: i_clk cycles per 1 ms tick (≥1).
- `MODE_W`, default 2: width of i_mode.
- `DUR_STEP_SEC`, default 10: seconds of run time per mode step.
- `SEC_W`, default 6: seconds counter width. Constraint: (2^MODE_W−1)·DUR_STEP_SEC ≤ 2^SEC_W−1 and 59 ≤ 2^SEC_W−1.
- `i_clk`  in  1  system clock; all state changes on its rising edge.
- `i_reset`  in  1  reset, asynchronous, active-low (asserted at 0).
- `i_mode`  in  MODE_W  0 = free-run; k>0 = timed run of k·DUR_STEP_SEC s.
- `i_pause`  in  1  level; 1 freezes prescaler, ms and s counters.
- `i_restart`  in  1  single-cycle pulse; clears counters and restarts the current mode.
- `o_sec`  out  SEC_W  elapsed seconds.
- `o_msec`  out  7  elapsed hundredths (r_msec/10, 0..99).
- `o_remain_sec`  out  SEC_W  target − o_sec in timed modes; 0 in free-run.
- `o_expired`  out  1  level; 1 while in EXPIRED.
- `o_done`  out  1  one-cycle pulse on entry to EXPIRED.
- `o_state`  out  2  00 FREE, 01 RUN, 10 EXPIRED.

## Operation
- Registers:
  - r_div: prescaler, 0..TICK_CYCLES−1.
  - r_msec: 10 bit, 0..999.
  - r_sec: SEC_W bit.
  - r_mode: last accepted mode.
  - r_state.
  - r_done.
- Target is r_mode·DUR_STEP_SEC, computed with an SEC_W-bit product.
- Per-cycle priority, highest first: reset > mode change (i_mode ≠ r_mode) > i_restart > i_pause > counting.
- **Mode change / restart:**
  - Clear r_div, r_msec and r_sec.
  - Load r_mode ← i_mode (mode change only).
  - Set state to FREE if the new or current mode is 0, otherwise RUN.
  - No o_done is generated.
- **Tick:** asserted when r_div == TICK_CYCLES−1 and the state is not EXPIRED and i_pause = 0. r_div wraps to 0.
- **ms counting:** on each tick, r_msec increments; at 999 it wraps to 0 and produces a second event.
- **FREE state:** on a second event, r_sec increments. At 59 it wraps to 0 (59 → 0, not 60).
- **RUN state:** on a second event:
  - If r_sec+1 == target: r_sec ← target, state → EXPIRED, r_done ← 1 for one cycle.
  - Otherwise r_sec increments.
- **EXPIRED state:**
  - All counters hold (r_msec = 0, r_sec = target).
  - Exits only via restart, mode change or reset.
- Pause in EXPIRED has no effect.
- o_msec, o_remain_sec and o_expired are combinational from registers. o_done is registered.

## Timing
- **Reset (i_reset = 0):**
  - All registers cleared immediately: r_state = FREE, r_mode = 0.
  - Outputs: o_sec = 0, o_msec = 0, o_remain_sec = 0, o_expired = 0, o_done = 0, o_state = 00.
- **Reset release with i_mode ≠ 0:** the first clock detects a mode change. Counters stay 0 and state → RUN on that edge.
- **Tick timing:** one tick every TICK_CYCLES running cycles. With TICK_CYCLES = 1, r_msec advances every cycle.
- **Second timing:** 1000 ticks after restart, o_sec = 1.
- **Expiry timing:**
  - Expiry is on the edge where the target-th second event occurs.
  - o_expired rises on that edge.
  - o_done is high for exactly the following cycle only.
- **Pause:** i_pause takes effect on the same edge. No tick is lost or duplicated across a pause. Resume continues from the held r_div.
- **Mode change and tick on the same edge:** the mode change wins; counters read 0 after the edge.
- **Restart and expiring second event on the same edge:** restart wins; no o_done; state RUN; counters 0.
- **Reset mid-run:** asynchronous clear, no o_done.

## Test plan
- **T1 free-run:** TICK_CYCLES = 1, i_mode = 0; run 60 000 cycles → o_sec goes 0..59 then back to 0; o_expired never 1; o_remain_sec = 0.
- **T2 timed expiry:** i_mode = 1, TICK_CYCLES = 2; run 20 000 cycles.
  - o_sec reaches 10 and o_remain_sec = 0.
  - o_expired = 1 and o_state = 10; o_done is exactly one 1-cycle pulse.
  - Counters hold for a further 5000 cycles.
- **T3 pause:** i_mode = 2; pause for 3000 cycles at o_sec = 5 → o_sec/o_msec frozen during the pause. Expiry occurs exactly 3000 cycles later than in the unpaused run, at o_sec = 20.
- **T4 mode change mid-run:** i_mode 3 → 1 at o_sec = 7 → next edge o_sec = 0, o_msec = 0, o_remain_sec = 10, state RUN; no o_done.
- **T5 collisions:**
  - Restart asserted on the expiring edge (mode 1) → no o_done, o_sec = 0, RUN.
  - Mode change on a second-event edge → counters 0.
- **T6 async reset:**
  - Drop i_reset between clock edges while in EXPIRED → all outputs 0 before the next edge.
  - Release with i_mode = 3 → RUN after the first edge, o_remain_sec = 30.
